// File: rtl/servant_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servant_arb_pkg
// Description : Shared types and constants for the servant_arb two-master
//               Wishbone arbiter (state enum, master indices, grant width).
// Revision    : 1.0 - initial release
// ============================================================================
package servant_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int   GRANT_W = 2;
    localparam logic M0      = 1'b0;
    localparam logic M1      = 1'b1;

    // Convert a master index into its one-hot {m1,m0} grant vector
    function automatic logic [GRANT_W-1:0] idx_to_grant(input logic idx);
        return (idx == M1) ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servant_arb_wdog.sv
`default_nettype none
// ============================================================================
// Module      : servant_arb_wdog
// Description : Bus-cycle watchdog for servant_arb. Counts enabled cycles
//               since the last clear and flags the TIMEOUT-th one.
// Revision    : 1.0 - initial release
// ============================================================================
module servant_arb_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // Count value held during the TIMEOUT-th enabled cycle
    localparam logic [15:0] C_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_cnt_q;
    logic [15:0] w_cnt_d;

    // Next count: clear wins, otherwise count up and park at the last value
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_clear) begin
            w_cnt_d = '0;
        end else if (i_enable && (r_cnt_q != C_LAST)) begin
            w_cnt_d = r_cnt_q + 16'd1;
        end
    end

    assign o_expired = i_enable && (r_cnt_q == C_LAST);

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/servant_arb.sv
`default_nettype none
// ============================================================================
// Module      : servant_arb
// Description : Two-master Wishbone arbiter in front of a shared RAM slave.
//               Round-robin or fixed-priority tie-break, one transfer per
//               grant, idle turnaround cycle between grants.
//               Optional bus watchdog enabled by SERVANT_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module servant_arb
    import servant_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst,
    input  logic [AW-1:0] i_wb_m0_adr,
    input  logic [31:0]   i_wb_m0_dat,
    input  logic [3:0]    i_wb_m0_sel,
    input  logic          i_wb_m0_we,
    input  logic          i_wb_m0_cyc,
    output logic [31:0]   o_wb_m0_rdt,
    output logic          o_wb_m0_ack,
    input  logic [AW-1:0] i_wb_m1_adr,
    input  logic [31:0]   i_wb_m1_dat,
    input  logic [3:0]    i_wb_m1_sel,
    input  logic          i_wb_m1_we,
    input  logic          i_wb_m1_cyc,
    output logic [31:0]   o_wb_m1_rdt,
    output logic          o_wb_m1_ack,
    output logic [AW-1:0] o_wb_s_adr,
    output logic [31:0]   o_wb_s_dat,
    output logic [3:0]    o_wb_s_sel,
    output logic          o_wb_s_we,
    output logic          o_wb_s_cyc,
    input  logic [31:0]   i_wb_s_rdt,
    input  logic          i_wb_s_ack,
    output logic [1:0]    o_grant,
    output logic          o_timeout
);

    if ((TIMEOUT < 2) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("servant_arb: TIMEOUT must be within 2..65535");
    end

    state_t             r_state_q, w_state_d;
    logic [GRANT_W-1:0] r_grant_q, w_grant_d;
    logic               r_last_q,  w_last_d;
    logic               w_winner;
    logic               w_busy;
    logic               w_owner;
    logic               w_owner_cyc;
    logic               w_abort;
    logic               w_ack;

    assign w_busy      = (r_state_q == BUSY);
    assign w_owner     = r_grant_q[1] ? M1 : M0;
    assign w_owner_cyc = (w_owner == M1) ? i_wb_m1_cyc : i_wb_m0_cyc;

`ifdef SERVANT_ARB_TIMEOUT_EN
    logic w_expired;
    logic w_clear;

    // Counter is held clear while idle so it starts from zero on every grant
    assign w_clear = (r_state_q == IDLE);

    servant_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (i_wb_clk),
        .rst       (i_wb_rst),
        .i_clear   (w_clear),
        .i_enable  (w_busy),
        .o_expired (w_expired)
    );

    // A real slave ack in the expiry cycle is a normal completion
    assign w_abort = w_busy && w_owner_cyc && w_expired && !i_wb_s_ack;
`else
    assign w_abort = 1'b0;
`endif

    // Next-state: pick a winner in IDLE, release the bus on ack/abort/drop
    always_comb begin
        w_state_d = r_state_q;
        w_grant_d = r_grant_q;
        w_last_d  = r_last_q;
        w_winner  = M0;
        case (r_state_q)
            IDLE: begin
                if (i_wb_m0_cyc || i_wb_m1_cyc) begin
                    if (i_wb_m0_cyc && i_wb_m1_cyc) begin
                        w_winner = (FIXED_PRIO != 0) ? M0 : ~r_last_q;
                    end else begin
                        w_winner = i_wb_m1_cyc ? M1 : M0;
                    end
                    w_grant_d = idx_to_grant(w_winner);
                    w_state_d = BUSY;
                end
            end
            BUSY: begin
                if (!w_owner_cyc || i_wb_s_ack || w_abort) begin
                    w_grant_d = '0;
                    w_last_d  = w_owner;
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_grant_d = '0;
                w_state_d = IDLE;
            end
        endcase
    end

    // State, grant and last-owner registers; last owner resets to m1
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_state_q <= IDLE;
            r_grant_q <= '0;
            r_last_q  <= M1;
        end else begin
            r_state_q <= w_state_d;
            r_grant_q <= w_grant_d;
            r_last_q  <= w_last_d;
        end
    end

    // Slave request follows the granted master; bus is quiet while idle
    always_comb begin
        o_wb_s_adr = '0;
        o_wb_s_dat = '0;
        o_wb_s_sel = '0;
        o_wb_s_we  = 1'b0;
        if (w_busy) begin
            if (w_owner == M1) begin
                o_wb_s_adr = i_wb_m1_adr;
                o_wb_s_dat = i_wb_m1_dat;
                o_wb_s_sel = i_wb_m1_sel;
                o_wb_s_we  = i_wb_m1_we;
            end else begin
                o_wb_s_adr = i_wb_m0_adr;
                o_wb_s_dat = i_wb_m0_dat;
                o_wb_s_sel = i_wb_m0_sel;
                o_wb_s_we  = i_wb_m0_we;
            end
        end
    end

    assign o_wb_s_cyc = w_busy && w_owner_cyc && !w_abort;

    // Responses are steered to the grant holder; an abort returns zero data
    assign w_ack       = i_wb_s_ack || w_abort;
    assign o_wb_m0_ack = w_ack && r_grant_q[0];
    assign o_wb_m1_ack = w_ack && r_grant_q[1];
    assign o_wb_m0_rdt = (r_grant_q[0] && !w_abort) ? i_wb_s_rdt : 32'd0;
    assign o_wb_m1_rdt = (r_grant_q[1] && !w_abort) ? i_wb_s_rdt : 32'd0;

    assign o_grant   = r_grant_q;
    assign o_timeout = w_abort;

endmodule
`default_nettype wire

// File: tb/tb_servant_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_servant_arb
// Description : Self-checking bench for servant_arb: directed scenarios plus
//               a randomized phase checked against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servant_arb;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [31:0]   m0_dat, m1_dat;
    logic [3:0]    m0_sel, m1_sel;
    logic          m0_we, m1_we, m0_cyc, m1_cyc;
    logic [31:0]   m0_rdt, m1_rdt;
    logic          m0_ack, m1_ack;
    logic [AW-1:0] s_adr;
    logic [31:0]   s_dat;
    logic [3:0]    s_sel;
    logic          s_we, s_cyc;
    logic [31:0]   s_rdt;
    logic          s_ack;
    logic [1:0]    grant;
    logic          tmo;

    // Second instance with fixed priority and its own one-wait-state slave
    logic [31:0]   f_m0_rdt, f_m1_rdt;
    logic          f_m0_ack, f_m1_ack;
    logic [AW-1:0] f_s_adr;
    logic [31:0]   f_s_dat;
    logic [3:0]    f_s_sel;
    logic          f_s_we, f_s_cyc;
    logic          f_s_ack = 1'b0;
    logic [1:0]    f_grant;
    logic          f_tmo;

    int checks   = 0;
    int failures = 0;
    int tmo_pulses = 0;
    int fix_m0_acks = 0;
    int fix_m1_acks = 0;
    logic fix_win = 1'b0;

    always #5 clk = ~clk;

    servant_arb #(.AW(AW), .FIXED_PRIO(0), .TIMEOUT(4)) u_dut (
        .i_wb_clk(clk), .i_wb_rst(rst),
        .i_wb_m0_adr(m0_adr), .i_wb_m0_dat(m0_dat), .i_wb_m0_sel(m0_sel),
        .i_wb_m0_we(m0_we), .i_wb_m0_cyc(m0_cyc),
        .o_wb_m0_rdt(m0_rdt), .o_wb_m0_ack(m0_ack),
        .i_wb_m1_adr(m1_adr), .i_wb_m1_dat(m1_dat), .i_wb_m1_sel(m1_sel),
        .i_wb_m1_we(m1_we), .i_wb_m1_cyc(m1_cyc),
        .o_wb_m1_rdt(m1_rdt), .o_wb_m1_ack(m1_ack),
        .o_wb_s_adr(s_adr), .o_wb_s_dat(s_dat), .o_wb_s_sel(s_sel),
        .o_wb_s_we(s_we), .o_wb_s_cyc(s_cyc),
        .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack),
        .o_grant(grant), .o_timeout(tmo)
    );

    servant_arb #(.AW(AW), .FIXED_PRIO(1), .TIMEOUT(255)) u_fix (
        .i_wb_clk(clk), .i_wb_rst(rst),
        .i_wb_m0_adr(m0_adr), .i_wb_m0_dat(m0_dat), .i_wb_m0_sel(m0_sel),
        .i_wb_m0_we(m0_we), .i_wb_m0_cyc(m0_cyc),
        .o_wb_m0_rdt(f_m0_rdt), .o_wb_m0_ack(f_m0_ack),
        .i_wb_m1_adr(m1_adr), .i_wb_m1_dat(m1_dat), .i_wb_m1_sel(m1_sel),
        .i_wb_m1_we(m1_we), .i_wb_m1_cyc(m1_cyc),
        .o_wb_m1_rdt(f_m1_rdt), .o_wb_m1_ack(f_m1_ack),
        .o_wb_s_adr(f_s_adr), .o_wb_s_dat(f_s_dat), .o_wb_s_sel(f_s_sel),
        .o_wb_s_we(f_s_we), .o_wb_s_cyc(f_s_cyc),
        .i_wb_s_rdt(32'h0F0F_0F0F), .i_wb_s_ack(f_s_ack),
        .o_grant(f_grant), .o_timeout(f_tmo)
    );

    always @(posedge clk) begin
        f_s_ack <= f_s_cyc && !f_s_ack;
        if (tmo) tmo_pulses <= tmo_pulses + 1;
        if (fix_win && f_m0_ack) fix_m0_acks <= fix_m0_acks + 1;
        if (fix_win && f_m1_ack) fix_m1_acks <= fix_m1_acks + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random-phase model state
    logic [1:0]  pend;
    logic [31:0] radr [2];
    logic [31:0] rdat [2];
    logic [3:0]  rsel [2];
    logic        rwe  [2];
    int owner, last, age, lat;
    int issued [2];
    int done   [2];

    initial begin
        rst = 1'b1;
        m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0;
        m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0;
        s_rdt = '0; s_ack = 1'b0;
        tick(); tick();
        chk("rst_grant", 64'(grant), 64'(2'b00));
        chk("rst_scyc",  64'(s_cyc), 64'(0));
        chk("rst_m0ack", 64'(m0_ack), 64'(0));
        chk("rst_m1ack", 64'(m1_ack), 64'(0));
        chk("rst_tmo",   64'(tmo), 64'(0));
        rst = 1'b0;
        tick();

        // m0 read of 0x10, slave acks one cycle after seeing cyc
        m0_cyc = 1'b1; m0_adr = 32'h10; m0_we = 1'b0; m0_sel = 4'hF;
        #1;
        chk("rd_idle_scyc", 64'(s_cyc), 64'(0));
        tick();
        chk("rd_grant", 64'(grant), 64'(2'b01));
        chk("rd_scyc",  64'(s_cyc), 64'(1));
        chk("rd_sadr",  64'(s_adr), 64'(32'h10));
        chk("rd_early_ack", 64'(m0_ack), 64'(0));
        tick();
        s_ack = 1'b1; s_rdt = 32'h1234_5678;
        #1;
        chk("rd_m0ack", 64'(m0_ack), 64'(1));
        chk("rd_m0rdt", 64'(m0_rdt), 64'(32'h1234_5678));
        chk("rd_m1ack", 64'(m1_ack), 64'(0));
        chk("rd_m1rdt", 64'(m1_rdt), 64'(0));
        tick();
        m0_cyc = 1'b0; s_ack = 1'b0;
        #1;
        chk("rd_release", 64'(grant), 64'(2'b00));

        // m1 write while m0 inputs wiggle without cyc
        m1_cyc = 1'b1; m1_adr = 32'h0000_2000; m1_dat = 32'hDEAD_BEEF;
        m1_sel = 4'b0011; m1_we = 1'b1;
        tick();
        chk("wr_grant", 64'(grant), 64'(2'b10));
        chk("wr_sadr",  64'(s_adr), 64'(32'h0000_2000));
        chk("wr_sdat",  64'(s_dat), 64'(32'hDEAD_BEEF));
        chk("wr_ssel",  64'(s_sel), 64'(4'b0011));
        chk("wr_swe",   64'(s_we),  64'(1));
        m0_adr = $urandom; m0_dat = $urandom; m0_sel = 4'hC; m0_we = 1'b0;
        #1;
        chk("wr_iso_adr", 64'(s_adr), 64'(32'h0000_2000));
        chk("wr_iso_dat", 64'(s_dat), 64'(32'hDEAD_BEEF));
        chk("wr_iso_sel", 64'(s_sel), 64'(4'b0011));
        chk("wr_iso_we",  64'(s_we),  64'(1));
        tick();
        s_ack = 1'b1;
        #1;
        chk("wr_m1ack", 64'(m1_ack), 64'(1));
        chk("wr_m0ack", 64'(m0_ack), 64'(0));
        tick();
        m1_cyc = 1'b0; s_ack = 1'b0;
        tick();

        // Continuous contention: round-robin alternates from m0
        m0_cyc = 1'b1; m1_cyc = 1'b1; fix_win = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_grant", 64'(grant), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            tick();
            s_ack = 1'b1;
            #1;
            chk("rr_m0ack", 64'(m0_ack), (k % 2 == 0) ? 64'(1) : 64'(0));
            chk("rr_m1ack", 64'(m1_ack), (k % 2 == 0) ? 64'(0) : 64'(1));
            tick();
            s_ack = 1'b0;
            #1;
            chk("rr_turnaround", 64'(grant), 64'(2'b00));
        end
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        tick();
        fix_win = 1'b0;
        tick();
        chk("fix_m1_starved", 64'(fix_m1_acks), 64'(0));
        chk("fix_m0_served", 64'(fix_m0_acks >= 3), 64'(1));

        // Reset while BUSY aborts silently; next tie goes to m0
        m1_cyc = 1'b1;
        tick();
        chk("rstb_grant", 64'(grant), 64'(2'b10));
        rst = 1'b1;
        tick();
        chk("rstb_grant0", 64'(grant), 64'(2'b00));
        chk("rstb_scyc",   64'(s_cyc), 64'(0));
        chk("rstb_m0ack",  64'(m0_ack), 64'(0));
        chk("rstb_m1ack",  64'(m1_ack), 64'(0));
        rst = 1'b0; m0_cyc = 1'b1;
        tick();
        chk("rstb_tie", 64'(grant), 64'(2'b01));
        tick();
        s_ack = 1'b1;
        #1;
        chk("rstb_m0ack2", 64'(m0_ack), 64'(1));
        tick();
        s_ack = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0;
        tick();

        // Owner drops cyc without ack, then the tie goes to the other master
        m0_cyc = 1'b1;
        tick();
        chk("drop_grant", 64'(grant), 64'(2'b01));
        m0_cyc = 1'b0;
        #1;
        chk("drop_scyc", 64'(s_cyc), 64'(0));
        tick();
        chk("drop_release", 64'(grant), 64'(2'b00));
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        tick();
        chk("drop_tie", 64'(grant), 64'(2'b10));
        tick();
        s_ack = 1'b1;
        #1;
        chk("drop_m1ack", 64'(m1_ack), 64'(1));
        tick();
        s_ack = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0;
        tick();

        // Slave never answers m0
        m0_cyc = 1'b1; s_rdt = 32'hA5A5_A5A5;
        tick(); tick(); tick();
        chk("to_b3_ack", 64'(m0_ack), 64'(0));
        chk("to_b3_tmo", 64'(tmo), 64'(0));
        tick();
`ifdef SERVANT_ARB_TIMEOUT_EN
        chk("to_ack",  64'(m0_ack), 64'(1));
        chk("to_rdt",  64'(m0_rdt), 64'(0));
        chk("to_tmo",  64'(tmo), 64'(1));
        chk("to_scyc", 64'(s_cyc), 64'(0));
        m0_cyc = 1'b0;
        tick();
        chk("to_release", 64'(grant), 64'(2'b00));
        chk("to_tmo_off", 64'(tmo), 64'(0));
`else
        for (int k = 0; k < 6; k++) begin
            chk("noto_ack", 64'(m0_ack), 64'(0));
            chk("noto_tmo", 64'(tmo), 64'(0));
            chk("noto_scyc", 64'(s_cyc), 64'(1));
            tick();
        end
        m0_cyc = 1'b0;
        tick();
        chk("noto_release", 64'(grant), 64'(2'b00));
`endif

        // Slave ack in the expiry cycle is a normal completion
        m1_cyc = 1'b1;
        tick(); tick(); tick(); tick();
        s_ack = 1'b1; s_rdt = 32'h55AA_33CC;
        #1;
        chk("race_ack", 64'(m1_ack), 64'(1));
        chk("race_rdt", 64'(m1_rdt), 64'(32'h55AA_33CC));
        chk("race_tmo", 64'(tmo), 64'(0));
        tick();
        s_ack = 1'b0; m1_cyc = 1'b0;
        tick();
`ifdef SERVANT_ARB_TIMEOUT_EN
        chk("tmo_pulses", 64'(tmo_pulses), 64'(1));
`else
        chk("tmo_pulses", 64'(tmo_pulses), 64'(0));
`endif

        // Randomized traffic against a transaction-level arbitration model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pend = 2'b00; owner = -1; last = 1; age = 0; lat = 2;
        issued[0] = 0; issued[1] = 0; done[0] = 0; done[1] = 0;
        for (int i = 0; i < 2; i++) begin
            radr[i] = '0; rdat[i] = '0; rsel[i] = '0; rwe[i] = 1'b0;
        end
        for (int c = 0; c < 700; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (c < 640 && !pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    radr[i] = $urandom; rdat[i] = $urandom;
                    rsel[i] = 4'($urandom); rwe[i] = 1'($urandom);
                    issued[i]++;
                end
            end
            m0_cyc = pend[0]; m0_adr = radr[0]; m0_dat = rdat[0]; m0_sel = rsel[0]; m0_we = rwe[0];
            m1_cyc = pend[1]; m1_adr = radr[1]; m1_dat = rdat[1]; m1_sel = rsel[1]; m1_we = rwe[1];
            s_rdt = $urandom;
            s_ack = (owner >= 0) ? (age == lat) : 1'($urandom_range(0, 1));
            #1;
            chk("rnd_grant", 64'(grant), (owner < 0) ? 64'(0) : (owner == 0 ? 64'(1) : 64'(2)));
            chk("rnd_scyc", 64'(s_cyc), 64'(owner >= 0));
            if (owner >= 0) begin
                chk("rnd_sadr", 64'(s_adr), 64'(radr[owner]));
                chk("rnd_sdat", 64'(s_dat), 64'(rdat[owner]));
                chk("rnd_ssel", 64'(s_sel), 64'(rsel[owner]));
                chk("rnd_swe",  64'(s_we),  64'(rwe[owner]));
            end
            chk("rnd_m0ack", 64'(m0_ack), 64'(owner == 0 && s_ack));
            chk("rnd_m1ack", 64'(m1_ack), 64'(owner == 1 && s_ack));
            chk("rnd_m0rdt", 64'(m0_rdt), (owner == 0) ? 64'(s_rdt) : 64'(0));
            chk("rnd_m1rdt", 64'(m1_rdt), (owner == 1) ? 64'(s_rdt) : 64'(0));
            if (owner >= 0) begin
                if (s_ack) begin
                    pend[owner] = 1'b0;
                    done[owner]++;
                    last  = owner;
                    owner = -1;
                end else begin
                    age++;
                end
            end else if (pend != 2'b00) begin
                if (pend == 2'b11) owner = (last == 1) ? 0 : 1;
                else               owner = pend[1] ? 1 : 0;
                age = 1;
                lat = $urandom_range(2, 3);
            end
            tick();
        end
        s_ack = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0;
        chk("rnd_drained", 64'(pend), 64'(0));
        chk("rnd_m0_done", 64'(done[0]), 64'(issued[0]));
        chk("rnd_m1_done", 64'(done[1]), 64'(issued[1]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/servant_arb.md
SERVANT_ARB -- requirements
Module: servant_arb

Interface
REQ-001 Parameter AW, default 32: address width of all Wishbone address ports.
REQ-002 Parameter FIXED_PRIO, default 0: 0 = round-robin tie-break, 1 = m0 always wins ties.
REQ-003 Parameter TIMEOUT, default 255: cycles the block waits for slave ack before aborting (range 2..65535).
REQ-004 Port i_wb_clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port i_wb_rst, input, 1: reset, synchronous and active-high.
REQ-006 Ports i_wb_m0_adr / i_wb_m1_adr, input, AW: master address.
REQ-007 Ports i_wb_m0_dat / i_wb_m1_dat, input, 32: master write data.
REQ-008 Ports i_wb_m0_sel / i_wb_m1_sel, input, 4: master byte selects.
REQ-009 Ports i_wb_m0_we / i_wb_m1_we, input, 1: master write enable.
REQ-010 Ports i_wb_m0_cyc / i_wb_m1_cyc, input, 1: master request, held until ack.
REQ-011 Ports o_wb_m0_rdt / o_wb_m1_rdt, output, 32: read data to master.
REQ-012 Ports o_wb_m0_ack / o_wb_m1_ack, output, 1: single-cycle ack to master.
REQ-013 Ports o_wb_s_adr (AW), o_wb_s_dat (32), o_wb_s_sel (4), o_wb_s_we (1), o_wb_s_cyc (1), outputs: shared RAM slave request.
REQ-014 Ports i_wb_s_rdt (32), i_wb_s_ack (1), inputs: slave response.
REQ-015 Port o_grant, output, 2: one-hot owner {m1,m0}; 2'b00 when idle.
REQ-016 Port o_timeout, output, 1: one-cycle pulse on a timeout abort.

Function
REQ-017 The state machine SHALL have states IDLE and BUSY.
REQ-018 IDLE: if any cyc is high, the block SHALL register the winner into o_grant and enter BUSY next cycle; o_wb_s_cyc SHALL be 0 in IDLE.
REQ-019 Tie (both cyc high in IDLE): FIXED_PRIO=1 grants m0; FIXED_PRIO=0 grants the master not granted last.
REQ-020 BUSY: slave adr/dat/sel/we/cyc SHALL be driven combinationally from the granted master; the other master's inputs are ignored.
REQ-021 Master ack SHALL equal i_wb_s_ack AND its grant bit; rdt SHALL equal i_wb_s_rdt for the granted master and 0 otherwise.
REQ-022 On i_wb_s_ack in BUSY, the block SHALL return to IDLE next cycle, clear o_grant and record the owner as last-granted.
REQ-023 Latency: cyc at cycle t -> o_wb_s_cyc at t+1 -> earliest master ack at t+2; one idle turnaround cycle between back-to-back grants.
REQ-024 If the granted master drops cyc in BUSY without ack, the block SHALL return to IDLE next cycle, deassert o_wb_s_cyc and update last-granted.
REQ-025 A losing master SHALL keep waiting; no request is dropped, and under continuous contention with FIXED_PRIO=0 grants SHALL alternate.

Reset
REQ-026 On i_wb_rst: state=IDLE, o_grant=0, last-granted=m1 (first tie goes to m0), timeout counter=0, o_timeout=0; all master acks and o_wb_s_cyc SHALL be 0 in the cycle after reset.
REQ-027 Reset mid-transaction SHALL abort silently with no ack to either master.

Configuration
REQ-028 With SERVANT_ARB_TIMEOUT_EN defined: a counter SHALL clear on entering BUSY and increment each BUSY cycle; when it reaches TIMEOUT without slave ack, the block SHALL assert the owner's ack for one cycle with rdt=0, pulse o_timeout, deassert o_wb_s_cyc and return to IDLE.
REQ-029 A slave ack in the same cycle the count reaches TIMEOUT SHALL win; it is a normal completion and o_timeout stays 0.
REQ-030 Without SERVANT_ARB_TIMEOUT_EN: no counter is built, o_timeout is tied 0 and BUSY waits indefinitely.

Structure
REQ-031 Package servant_arb_pkg SHALL hold the state enum (IDLE, BUSY), the master index constants (M0=0, M1=1) and the grant width constant.
REQ-032 The timeout counter SHALL be sub-module servant_arb_wdog (inputs clear and enable; output expired), instantiated only under SERVANT_ARB_TIMEOUT_EN.

Verification
REQ-033 m0 read of adr 0x10 alone, slave acks 1 cycle after cyc -> o_grant=01 at t+1, o_wb_m0_ack at t+2, o_wb_m0_rdt=i_wb_s_rdt, o_wb_m1_ack=0.
REQ-034 Both masters request from reset, FIXED_PRIO=0 -> grant order m0, m1, m0, m1 over 4 transactions; FIXED_PRIO=1 -> m0 is served continuously while it requests.
REQ-035 m1 write 0xDEADBEEF, sel=4'b0011 -> slave sees the same adr/dat/sel with we=1; m0 inputs toggling meanwhile do not reach the slave.
REQ-036 Reset asserted while BUSY before ack -> next cycle o_grant=0, o_wb_s_cyc=0, no master ack; next tie goes to m0.
REQ-037 TIMEOUT=4, macro defined, slave never acks -> after 4 BUSY cycles the owner gets ack with rdt=0, o_timeout pulses once, state returns to IDLE; macro undefined -> no ack, o_timeout stays 0.
